// File: rtl/ms_mul_job_sched.sv
// ms_mul_job_sched
// Round-robin job scheduler in front of one shared stochastic ordered-CAS
// multiplier datapath. A granted job's operands are latched, the datapath is
// sequenced through CLEAR (held in reset), RUN (enabled until done) and DRAIN,
// and the binary product is returned with the requester ID on a valid/ready
// response port. Every output is driven straight from a register.
//
// Optional feature: define MS_MUL_SCHED_WATCHDOG_EN to build a RUN-cycle
// watchdog that aborts a job after TIMEOUT_CYCLES RUN cycles without dp_done
// (response carries rsp_result=0, rsp_timeout=1). Without the macro no counter
// exists, RUN waits for dp_done indefinitely and rsp_timeout is constant 0.

module ms_mul_job_sched #(
    parameter int DATA_WIDTH     = 5,
    parameter int NUM_INPUTS     = 2,
    parameter int WXIP1          = DATA_WIDTH * NUM_INPUTS + 1,
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 1032
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req_valid,
    input  logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0] req_operands,
    output logic [NUM_REQ-1:0]                       req_ready,
    output logic                                     dp_rst,
    output logic                                     dp_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]         dp_operands,
    input  logic                                     dp_done,
    input  logic [WXIP1-1:0]                         dp_result,
    output logic                                     rsp_valid,
    input  logic                                     rsp_ready,
    output logic [ID_W-1:0]                          rsp_id,
    output logic [WXIP1-1:0]                         rsp_result,
    output logic                                     rsp_timeout
);

    localparam int SLICE_W = NUM_INPUTS * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t               r_state;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [NUM_REQ-1:0]   r_req_ready;
    logic                 r_dp_rst;
    logic                 r_dp_en;
    logic [SLICE_W-1:0]   r_dp_operands;
    logic                 r_rsp_valid;
    logic [ID_W-1:0]      r_rsp_id;
    logic [WXIP1-1:0]     r_rsp_result;
    logic                 r_clr_cnt;    // second CLEAR cycle marker
    logic                 r_run_first;  // high during the first RUN cycle only

`ifdef MS_MUL_SCHED_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]     r_run_cnt;     // RUN cycles already completed
    logic                 r_timeout_hit; // current job left RUN via the watchdog
    logic                 r_rsp_timeout;
`else
    logic [31:0]          w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES;
`endif

    // Per-requester operand slices, split once so the grant mux can index them.
    logic [SLICE_W-1:0]   w_req_ops [NUM_REQ];

    for (genvar j = 0; j < NUM_REQ; j++) begin : g_slice
        assign w_req_ops[j] = req_operands[j*SLICE_W +: SLICE_W];
    end

    logic                 w_gnt_any;
    logic [ID_W-1:0]      w_gnt_idx;
    logic [NUM_REQ-1:0]   w_gnt_onehot;
    logic [SLICE_W-1:0]   w_gnt_ops;
    logic [ID_W-1:0]      w_rr_next;

    // Round-robin pick: first valid requester at or after r_rr_ptr, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        // Walk offsets from farthest to nearest so the nearest valid one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int              v_pos;
            logic [ID_W-1:0] v_idx;
            v_pos = int'(r_rr_ptr) + k;
            if (v_pos >= NUM_REQ) begin
                v_pos = v_pos - NUM_REQ;
            end
            v_idx = ID_W'(v_pos);
            if (req_valid[v_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = v_idx;
            end
        end
    end

    // Grant side information derived from the picked index.
    always_comb begin
        w_gnt_onehot = NUM_REQ'(1) << w_gnt_idx;
        w_gnt_ops    = w_req_ops[w_gnt_idx];
        if (w_gnt_idx == ID_W'(NUM_REQ - 1)) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_gnt_idx + ID_W'(1);
        end
    end

    // Job sequencer: arbitration, datapath control and response, all registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_req_ready   <= '0;
            r_dp_rst      <= 1'b1;
            r_dp_en       <= 1'b0;
            r_dp_operands <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_result  <= '0;
            r_clr_cnt     <= 1'b0;
            r_run_first   <= 1'b0;
`ifdef MS_MUL_SCHED_WATCHDOG_EN
            r_run_cnt     <= '0;
            r_timeout_hit <= 1'b0;
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // branch below reads the pre-edge values regardless of order.
            r_req_ready <= '0;
            case (r_state)
                S_IDLE: begin
                    r_dp_rst <= 1'b0;
                    if (w_gnt_any) begin
                        r_req_ready   <= w_gnt_onehot;
                        r_dp_operands <= w_gnt_ops;
                        r_rsp_id      <= w_gnt_idx;
                        r_rr_ptr      <= w_rr_next;
                        r_dp_rst      <= 1'b1;
                        r_clr_cnt     <= 1'b0;
                        r_state       <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt) begin
                        r_dp_rst    <= 1'b0;
                        r_dp_en     <= 1'b1;
                        r_run_first <= 1'b1;
`ifdef MS_MUL_SCHED_WATCHDOG_EN
                        r_run_cnt   <= '0;
`endif
                        r_state     <= S_RUN;
                    end else begin
                        r_clr_cnt   <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_run_first <= 1'b0;
                    // Done straight out of reset is spurious; only trust it later.
                    if (!r_run_first && dp_done) begin
                        r_dp_en       <= 1'b0;
`ifdef MS_MUL_SCHED_WATCHDOG_EN
                        r_timeout_hit <= 1'b0;
`endif
                        r_state       <= S_DRAIN;
                    end
`ifdef MS_MUL_SCHED_WATCHDOG_EN
                    else if (r_run_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_dp_en       <= 1'b0;
                        r_timeout_hit <= 1'b1;
                        r_state       <= S_DRAIN;
                    end else begin
                        r_run_cnt     <= r_run_cnt + CNT_W'(1);
                    end
`endif
                end
                S_DRAIN: begin
`ifdef MS_MUL_SCHED_WATCHDOG_EN
                    r_rsp_result  <= r_timeout_hit ? '0 : dp_result;
                    r_rsp_timeout <= r_timeout_hit;
`else
                    r_rsp_result  <= dp_result;
`endif
                    r_rsp_valid   <= 1'b1;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign dp_rst      = r_dp_rst;
    assign dp_en       = r_dp_en;
    assign dp_operands = r_dp_operands;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_result  = r_rsp_result;
`ifdef MS_MUL_SCHED_WATCHDOG_EN
    assign rsp_timeout = r_rsp_timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ms_mul_job_sched.sv
// Directed testbench for ms_mul_job_sched (4 requesters, two 5-bit operands).
// Outputs are sampled and inputs driven on the falling clock edge. When built
// with MS_MUL_SCHED_WATCHDOG_EN the watchdog scenarios run (TIMEOUT_CYCLES=16);
// otherwise a long RUN without dp_done is checked to never abort.

module tb_ms_mul_job_sched;

    localparam int DW  = 5;
    localparam int NI  = 2;
    localparam int WX  = 11;
    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int TO  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*NI*DW-1:0] req_operands;
    logic [NR-1:0]    req_ready;
    logic             dp_rst;
    logic             dp_en;
    logic [NI*DW-1:0] dp_operands;
    logic             dp_done;
    logic [WX-1:0]    dp_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [WX-1:0]    rsp_result;
    logic             rsp_timeout;

    int checks = 0;
    int errors = 0;

    ms_mul_job_sched #(
        .DATA_WIDTH     (DW),
        .NUM_INPUTS     (NI),
        .WXIP1          (WX),
        .NUM_REQ        (NR),
        .ID_W           (IDW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_operands (req_operands),
        .req_ready    (req_ready),
        .dp_rst       (dp_rst),
        .dp_en        (dp_en),
        .dp_operands  (dp_operands),
        .dp_done      (dp_done),
        .dp_result    (dp_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_timeout  (rsp_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    // Step to the next falling edge, counting cycles until a grant pulse.
    task automatic wait_grant(output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            n++;
            if (req_ready != '0) ok = 1'b1;
        end
    endtask

    // Step to the next falling edge, counting cycles until rsp_valid.
    task automatic wait_rsp(output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = '0; req_operands = '0;
        dp_done = 1'b0; dp_result = '0; rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dp_rst !== 1'b1 || dp_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_dp_ctrl: dp_rst=%b dp_en=%b, expected 1 0", dp_rst, dp_en);
        end
        checks++;
        if ({req_ready, dp_operands, rsp_valid, rsp_id, rsp_result, rsp_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req_ready=%b dp_operands=%h rsp_valid=%b rsp_id=%0d rsp_result=%0d rsp_timeout=%b, expected all 0",
                     req_ready, dp_operands, rsp_valid, rsp_id, rsp_result, rsp_timeout);
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({dp_rst, dp_en, req_ready, rsp_valid} !== 7'b0) begin
            errors++;
            $display("FAIL idle_after_reset: dp_rst=%b dp_en=%b req_ready=%b rsp_valid=%b, expected all 0",
                     dp_rst, dp_en, req_ready, rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0]    exp_g  [5];
        logic [IDW-1:0]   exp_id [5];
        int n;
        bit ok;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2;
        exp_id[3] = 2'd3; exp_id[4] = 2'd0;
        // Slice j carries operand0 = j+10, operand1 = j+1.
        req_operands = {5'd4, 5'd13, 5'd3, 5'd12, 5'd2, 5'd11, 5'd1, 5'd10};
        req_valid = 4'hF; dp_done = 1'b1; dp_result = 11'd5; rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [NI*DW-1:0] exp_ops;
            exp_ops = {5'(exp_id[i] + 1), 5'(exp_id[i] + 10)};
            wait_grant(n, ok);
            checks++;
            if (!ok || req_ready !== exp_g[i] || dp_operands !== exp_ops) begin
                errors++;
                $display("FAIL rr_grant%0d: req_ready=%b dp_operands=%h, expected %b %h",
                         i, req_ready, dp_operands, exp_g[i], exp_ops);
            end
            if (i > 0) begin
                checks++;
                if (n !== 2) begin
                    errors++;
                    $display("FAIL rr_spacing%0d: grant %0d cycles after response, expected 2", i, n);
                end
            end
            if (i == 4) req_valid = '0;
            wait_rsp(n, ok);
            checks++;
            if (!ok || rsp_id !== exp_id[i]) begin
                errors++;
                $display("FAIL rr_rsp_id%0d: rsp_id=%0d, expected %0d", i, rsp_id, exp_id[i]);
            end
        end
        @(negedge clk);
        dp_done = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_single_job();
        int n;
        bit ok;
        req_operands = '0;
        req_operands[2*NI*DW +: NI*DW] = {5'd5, 5'd3};
        req_valid = 4'b0100; dp_done = 1'b0; dp_result = 11'd15; rsp_ready = 1'b0;
        wait_grant(n, ok);  // grant pulse cycle (C1)
        checks++;
        if (!ok || req_ready !== 4'b0100 || dp_operands !== 10'h0A3 || dp_rst !== 1'b1 || dp_en !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b ops=%h dp_rst=%b dp_en=%b, expected 0100 0a3 1 0",
                     req_ready, dp_operands, dp_rst, dp_en);
        end
        req_valid = '0; req_operands = '0;
        @(negedge clk);  // C2: second CLEAR cycle, operands must stay latched
        checks++;
        if (req_ready !== 4'b0 || dp_rst !== 1'b1 || dp_operands !== 10'h0A3) begin
            errors++;
            $display("FAIL single_clear2: req_ready=%b dp_rst=%b ops=%h, expected 0000 1 0a3",
                     req_ready, dp_rst, dp_operands);
        end
        @(negedge clk);  // C3: first RUN cycle
        checks++;
        if (dp_rst !== 1'b0) begin
            errors++;
            $display("FAIL single_run_rst: dp_rst=%b, expected 0", dp_rst);
        end
        // RUN cycles C3..C10; dp_done raised during the 8th.
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (dp_en !== 1'b1 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_run%0d: dp_en=%b rsp_valid=%b, expected 1 0", k, dp_en, rsp_valid);
            end
            if (k == 8) dp_done = 1'b1;
            @(negedge clk);
        end
        dp_done = 1'b0;  // C11: DRAIN
        checks++;
        if (dp_en !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: dp_en=%b rsp_valid=%b, expected 0 0", dp_en, rsp_valid);
        end
        @(negedge clk);  // C12: response, 11 cycles after the grant pulse
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 11'd15 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: valid=%b id=%0d result=%0d timeout=%b, expected 1 2 15 0",
                     rsp_valid, rsp_id, rsp_result, rsp_timeout);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_handshake: rsp_valid=%b, expected 0", rsp_valid);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_early_done();
        int n;
        bit ok;
        req_operands = '0;
        req_operands[1*NI*DW +: NI*DW] = {5'd31, 5'd31};
        req_valid = 4'b0010; dp_done = 1'b1; dp_result = 11'd961; rsp_ready = 1'b1;
        wait_grant(n, ok);  // C1
        checks++;
        if (!ok || req_ready !== 4'b0010 || dp_operands !== 10'h3FF) begin
            errors++;
            $display("FAIL early_grant: req_ready=%b ops=%h, expected 0010 3ff", req_ready, dp_operands);
        end
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);  // C3: RUN 1, done ignored
        @(negedge clk);  // C4: RUN 2, still enabled
        checks++;
        if (dp_en !== 1'b1) begin
            errors++;
            $display("FAIL early_done_ignored: dp_en=%b in second RUN cycle, expected 1", dp_en);
        end
        @(negedge clk);  // C5: DRAIN
        checks++;
        if (dp_en !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_drain: dp_en=%b rsp_valid=%b, expected 0 0", dp_en, rsp_valid);
        end
        @(negedge clk);  // C6: response 5 cycles after the grant pulse
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 11'd961) begin
            errors++;
            $display("FAIL early_rsp: valid=%b id=%0d result=%0d, expected 1 1 961",
                     rsp_valid, rsp_id, rsp_result);
        end
        @(negedge clk);
        dp_done = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        bit ok;
        req_operands = '0;
        req_operands[3*NI*DW +: NI*DW] = {5'd2, 5'd9};
        req_operands[0 +: NI*DW]       = {5'd1, 5'd1};
        req_valid = 4'b1001; dp_done = 1'b1; dp_result = 11'd18; rsp_ready = 1'b0;
        wait_grant(n, ok);
        checks++;
        if (!ok || req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_grant_wrap: req_ready=%b, expected 1000", req_ready);
        end
        wait_rsp(n, ok);
        checks++;
        if (!ok || n !== 5) begin
            errors++;
            $display("FAIL bp_rsp_latency: %0d cycles, expected 5", n);
        end
        dp_result = 11'd0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, req_ready} !== {1'b1, 2'd3, 11'd18, 4'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b id=%0d result=%0d req_ready=%b, expected 1 3 18 0000",
                         i, rsp_valid, rsp_id, rsp_result, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);  // IDLE
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0) begin
            errors++;
            $display("FAIL bp_release: rsp_valid=%b req_ready=%b, expected 0 0000", rsp_valid, req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_next_grant: req_ready=%b, expected 0001", req_ready);
        end
        req_valid = '0; dp_done = 1'b0; rsp_ready = 1'b0;
    endtask

    // Continues the job granted to requester 0 at the end of test_backpressure.
    task automatic test_reset_mid_run();
        int n;
        bit ok;
        @(negedge clk);
        @(negedge clk);  // first RUN cycle
        checks++;
        if (dp_en !== 1'b1 || dp_rst !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre_run: dp_en=%b dp_rst=%b, expected 1 0", dp_en, dp_rst);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({dp_rst, dp_en, rsp_valid, req_ready, dp_operands} !== {1'b1, 1'b0, 1'b0, 4'b0, 10'd0}) begin
            errors++;
            $display("FAIL rst_async: dp_rst=%b dp_en=%b rsp_valid=%b req_ready=%b ops=%h, expected 1 0 0 0000 000",
                     dp_rst, dp_en, rsp_valid, req_ready, dp_operands);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'hF; dp_done = 1'b1; rsp_ready = 1'b1;
        wait_grant(n, ok);
        checks++;
        if (!ok || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rst_rr_restart: req_ready=%b, expected 0001", req_ready);
        end
        req_valid = '0;
        wait_rsp(n, ok);
        checks++;
        if (!ok || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL rst_rsp: rsp_id=%0d, expected 0", rsp_id);
        end
        @(negedge clk);
        dp_done = 1'b0; rsp_ready = 1'b0;
    endtask

`ifdef MS_MUL_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        bit ok;
        // Job 1: dp_done never arrives; abort after 16 RUN cycles.
        req_valid = 4'b0100; dp_done = 1'b0; dp_result = 11'd77; rsp_ready = 1'b0;
        wait_grant(n, ok);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 1; k <= TO; k++) begin
            checks++;
            if (dp_en !== 1'b1) begin
                errors++;
                $display("FAIL wd_run%0d: dp_en=%b, expected 1", k, dp_en);
            end
            @(negedge clk);
        end
        checks++;
        if (dp_en !== 1'b0) begin
            errors++;
            $display("FAIL wd_abort: dp_en=%b after %0d RUN cycles, expected 0", dp_en, TO);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_result !== 11'd0 || rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL wd_rsp: valid=%b timeout=%b result=%0d id=%0d, expected 1 1 0 2",
                     rsp_valid, rsp_timeout, rsp_result, rsp_id);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        // Job 2: dp_done arrives in the very cycle the watchdog expires.
        req_valid = 4'b1000;
        wait_grant(n, ok);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 1; k <= TO; k++) begin
            if (k == TO) dp_done = 1'b1;
            @(negedge clk);
        end
        dp_done = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_result !== 11'd77 || rsp_id !== 2'd3) begin
            errors++;
            $display("FAIL wd_tie: valid=%b timeout=%b result=%0d id=%0d, expected 1 0 77 3",
                     rsp_valid, rsp_timeout, rsp_result, rsp_id);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask
`else
    task automatic test_no_watchdog();
        int n;
        int en_cycles;
        bit ok;
        req_valid = 4'b0100; dp_done = 1'b0; dp_result = 11'd100; rsp_ready = 1'b0;
        wait_grant(n, ok);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        en_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (dp_en === 1'b1) en_cycles++;
            @(negedge clk);
        end
        checks++;
        if (en_cycles !== 40) begin
            errors++;
            $display("FAIL nowd_run_hold: dp_en high %0d of 40 cycles, expected 40", en_cycles);
        end
        dp_done = 1'b1;
        wait_rsp(n, ok);
        dp_done = 1'b0;
        checks++;
        if (!ok || n !== 2 || rsp_timeout !== 1'b0 || rsp_result !== 11'd100) begin
            errors++;
            $display("FAIL nowd_rsp: latency=%0d timeout=%b result=%0d, expected 2 0 100",
                     n, rsp_timeout, rsp_result);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single_job();
        test_early_done();
        test_backpressure();
        test_reset_mid_run();
`ifdef MS_MUL_SCHED_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
